// File: rtl/dfd_cla_pkg.sv
// Shared CLA types: sequencer stage configuration, sequencer state and default sizes.
package dfd_cla_pkg;

   localparam int CLA_SEQ_NUM_STAGES = 4;
   localparam int CLA_SEQ_NUM_MATCH  = 4;
   localparam int CLA_SEQ_CNT_W      = 16;
   // Wide enough to encode out-of-range unit selects (e.g. 7 with four units).
   localparam int CLA_SEQ_SEL_W      = 4;

   typedef enum logic [1:0] {
      CLA_SEQ_IDLE      = 2'd0,
      CLA_SEQ_RUN       = 2'd1,
      CLA_SEQ_TRIGGERED = 2'd2
   } ClaSeqState_e;

   typedef struct packed {
      logic [CLA_SEQ_SEL_W-1:0] match_sel;
      logic                     polarity;
      logic [CLA_SEQ_CNT_W-1:0] threshold;
   } ClaSeqStageCfg_s;

endpackage

// File: rtl/dfd_cla_seq_event_mux.sv
// Selects the active stage's event from the match-unit outputs; an out-of-range
// unit select matches no unit and therefore never produces an event.
module dfd_cla_seq_event_mux
   import dfd_cla_pkg::*;
#(
   parameter int NUM_MATCH = CLA_SEQ_NUM_MATCH
) (
   input  logic [CLA_SEQ_SEL_W-1:0] match_sel_i,
   input  logic                     polarity_i,
   input  logic [NUM_MATCH-1:0]     match_pos_i,
   input  logic [NUM_MATCH-1:0]     match_neg_i,
   output logic                     event_o
);

   logic [NUM_MATCH-1:0] hit;

   generate
      for (genvar gi = 0; gi < NUM_MATCH; gi++) begin : g_hit
         assign hit[gi] = (match_sel_i == CLA_SEQ_SEL_W'(gi)) &&
                          (polarity_i ? match_neg_i[gi] : match_pos_i[gi]);
      end
   endgenerate

   assign event_o = |hit;

endmodule

// File: rtl/dfd_cla_match_sequencer.sv
// CLA multi-stage event sequencer: counts selected match events per stage and
// raises a one-cycle trigger when the last programmed stage completes.
module dfd_cla_match_sequencer
   import dfd_cla_pkg::*;
#(
   parameter int  NUM_MATCH  = CLA_SEQ_NUM_MATCH,
   parameter int  NUM_STAGES = CLA_SEQ_NUM_STAGES,
   parameter int  CNT_W      = CLA_SEQ_CNT_W,
   localparam int NS_W       = $clog2(NUM_STAGES + 1),
   localparam int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               arm_i,
   input  logic                               disarm_i,
   input  logic                               clear_i,
   input  logic [NS_W-1:0]                    num_stages_i,
   input  ClaSeqStageCfg_s [NUM_STAGES-1:0]   stage_cfg_i,
   input  logic [NUM_MATCH-1:0]               match_pos_i,
   input  logic [NUM_MATCH-1:0]               match_neg_i,
   output logic                               trigger_o,
   output logic                               triggered_o,
   output logic                               busy_o,
   output logic [STG_W-1:0]                   cur_stage_o,
   output logic [CNT_W-1:0]                   occ_count_o
);

   ClaSeqState_e                     state_q, state_d;
   logic [STG_W-1:0]                 stage_q, stage_d;
   logic [CNT_W-1:0]                 occ_q, occ_d;
   logic                             trig_q, trig_d;
   logic [NS_W-1:0]                  num_q, num_d;
   ClaSeqStageCfg_s [NUM_STAGES-1:0] cfg_q, cfg_d;

   ClaSeqStageCfg_s  cur_cfg;
   logic             stage_event;
   logic [STG_W-1:0] last_stage;
   logic [CNT_W-1:0] thr_raw, thr_eff;
   logic [CNT_W:0]   occ_inc;
   logic             keep_counting;

   assign cur_cfg = cfg_q[stage_q];

   dfd_cla_seq_event_mux #(
      .NUM_MATCH (NUM_MATCH)
   ) u_event_mux (
      .match_sel_i (cur_cfg.match_sel),
      .polarity_i  (cur_cfg.polarity),
      .match_pos_i (match_pos_i),
      .match_neg_i (match_neg_i),
      .event_o     (stage_event)
   );

   // Zero stages behaves as one; oversized counts clamp to the last physical stage.
   always_comb begin
      last_stage = '0;
      if (num_q == '0)
         last_stage = '0;
      else if (num_q > NS_W'(NUM_STAGES))
         last_stage = STG_W'(NUM_STAGES - 1);
      else
         last_stage = STG_W'(num_q - 1'b1);
   end

   assign thr_raw       = CNT_W'(cur_cfg.threshold);
   assign thr_eff       = (thr_raw == '0) ? CNT_W'(1) : thr_raw;
   assign occ_inc       = {1'b0, occ_q} + (CNT_W + 1)'(1);
   assign keep_counting = occ_inc < {1'b0, thr_eff};

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= CLA_SEQ_IDLE;
         stage_q <= '0;
         occ_q   <= '0;
         trig_q  <= 1'b0;
         num_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         occ_q   <= occ_d;
         trig_q  <= trig_d;
         num_q   <= num_d;
         cfg_q   <= cfg_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      occ_d   = occ_q;
      trig_d  = 1'b0;
      num_d   = num_q;
      cfg_d   = cfg_q;
      if (disarm_i) begin
         state_d = CLA_SEQ_IDLE;
         stage_d = '0;
         occ_d   = '0;
      end else begin
         case (state_q)
            CLA_SEQ_IDLE: begin
               if (arm_i) begin
                  state_d = CLA_SEQ_RUN;
                  num_d   = num_stages_i;
                  cfg_d   = stage_cfg_i;
                  stage_d = '0;
                  occ_d   = '0;
               end
            end
            CLA_SEQ_RUN: begin
               // A re-arm restarts the chain and discards this cycle's event.
               if (arm_i) begin
                  num_d   = num_stages_i;
                  cfg_d   = stage_cfg_i;
                  stage_d = '0;
                  occ_d   = '0;
               end else if (stage_event) begin
                  if (keep_counting) begin
                     occ_d = occ_inc[CNT_W-1:0];
                  end else begin
                     occ_d = '0;
                     if (stage_q == last_stage) begin
                        state_d = CLA_SEQ_TRIGGERED;
                        trig_d  = 1'b1;
                     end else begin
                        stage_d = stage_q + 1'b1;
                     end
                  end
               end
            end
            CLA_SEQ_TRIGGERED: begin
               if (clear_i) begin
                  state_d = CLA_SEQ_IDLE;
                  stage_d = '0;
                  occ_d   = '0;
               end
            end
            default: begin
               state_d = CLA_SEQ_IDLE;
               stage_d = '0;
               occ_d   = '0;
            end
         endcase
      end
   end

   always_comb begin
      trigger_o   = trig_q;
      triggered_o = (state_q == CLA_SEQ_TRIGGERED);
      busy_o      = (state_q == CLA_SEQ_RUN);
      cur_stage_o = stage_q;
      occ_count_o = occ_q;
   end

endmodule

// File: tb/tb_dfd_cla_match_sequencer.sv
// Directed table-driven bench for the CLA match sequencer plus hand sequences
// for reset mid-run and an unreachable match unit.
module tb_dfd_cla_match_sequencer;
   import dfd_cla_pkg::*;

   logic                      clock_i;
   logic                      reset_i;
   logic                      arm_i;
   logic                      disarm_i;
   logic                      clear_i;
   logic [2:0]                num_stages_i;
   ClaSeqStageCfg_s [3:0]     stage_cfg_i;
   logic [3:0]                match_pos_i;
   logic [3:0]                match_neg_i;
   logic                      trigger_o;
   logic                      triggered_o;
   logic                      busy_o;
   logic [1:0]                cur_stage_o;
   logic [15:0]               occ_count_o;

   dfd_cla_match_sequencer #(
      .NUM_MATCH  (4),
      .NUM_STAGES (4),
      .CNT_W      (16)
   ) dut (
      .clock_i      (clock_i),
      .reset_i      (reset_i),
      .arm_i        (arm_i),
      .disarm_i     (disarm_i),
      .clear_i      (clear_i),
      .num_stages_i (num_stages_i),
      .stage_cfg_i  (stage_cfg_i),
      .match_pos_i  (match_pos_i),
      .match_neg_i  (match_neg_i),
      .trigger_o    (trigger_o),
      .triggered_o  (triggered_o),
      .busy_o       (busy_o),
      .cur_stage_o  (cur_stage_o),
      .occ_count_o  (occ_count_o)
   );

   initial clock_i = 1'b0;
   always #5 clock_i = ~clock_i;

   // Inputs for one cycle plus the outputs expected right after that edge.
   typedef struct packed {
      logic        arm;
      logic        dis;
      logic        clr;
      logic [2:0]  ns;
      logic [3:0]  sel0;
      logic        pol0;
      logic [15:0] thr0;
      logic [3:0]  sel1;
      logic        pol1;
      logic [15:0] thr1;
      logic [3:0]  mp;
      logic [3:0]  mn;
      logic        tg;
      logic        td;
      logic        bz;
      logic [1:0]  st;
      logic [15:0] oc;
   } vec_t;

   vec_t  tbl[$];
   string tags[$];
   int    total = 0;
   int    bad   = 0;

   function automatic vec_t mk(input logic a, input logic d, input logic c, input logic [2:0] ns,
                               input logic [3:0] s0, input logic p0, input logic [15:0] t0,
                               input logic [3:0] s1, input logic p1, input logic [15:0] t1,
                               input logic [3:0] mp, input logic [3:0] mn,
                               input logic tg, input logic td, input logic bz,
                               input logic [1:0] st, input logic [15:0] oc);
      vec_t v;
      v.arm = a;  v.dis = d;  v.clr = c;  v.ns = ns;
      v.sel0 = s0; v.pol0 = p0; v.thr0 = t0;
      v.sel1 = s1; v.pol1 = p1; v.thr1 = t1;
      v.mp = mp;  v.mn = mn;
      v.tg = tg;  v.td = td;  v.bz = bz;  v.st = st;  v.oc = oc;
      return v;
   endfunction

   function automatic void add(input string tag, input vec_t v);
      tbl.push_back(v);
      tags.push_back(tag);
   endfunction

   task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp,
                        input bit verbose);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got {trig,trd,busy,stg,occ}=%h expected=%h", name, got, exp);
      end else if (verbose) begin
         $display("ok   %s: {trig,trd,busy,stg,occ}=%h", name, got);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      @(negedge clock_i);
      arm_i        = v.arm;
      disarm_i     = v.dis;
      clear_i      = v.clr;
      num_stages_i = v.ns;
      stage_cfg_i  = '0;
      stage_cfg_i[0] = '{match_sel: v.sel0, polarity: v.pol0, threshold: v.thr0};
      stage_cfg_i[1] = '{match_sel: v.sel1, polarity: v.pol1, threshold: v.thr1};
      match_pos_i  = v.mp;
      match_neg_i  = v.mn;
      @(posedge clock_i);
      #1;
      check(name, {trigger_o, triggered_o, busy_o, cur_stage_o, occ_count_o},
            {v.tg, v.td, v.bz, v.st, v.oc}, 1'b1);
   endtask

   task automatic idle_inputs();
      arm_i = 1'b0; disarm_i = 1'b0; clear_i = 1'b0;
      match_pos_i = '0; match_neg_i = '0;
   endtask

   initial begin
      // args: arm dis clr ns | sel0 pol0 thr0 | sel1 pol1 thr1 | mp mn | trig trd busy stg occ
      add("A_arm",      mk(1,0,0,1, 2,0,1, 0,0,0, 4'h0,4'h0, 0,0,1,0,0));
      add("A_quiet",    mk(0,0,0,1, 2,0,1, 0,0,0, 4'h0,4'h0, 0,0,1,0,0));
      add("A_other",    mk(0,0,0,1, 2,0,1, 0,0,0, 4'h1,4'h4, 0,0,1,0,0));
      add("A_fire",     mk(0,0,0,1, 2,0,1, 0,0,0, 4'h4,4'h0, 1,1,0,0,0));
      add("A_hold",     mk(0,0,0,1, 2,0,1, 0,0,0, 4'h0,4'h0, 0,1,0,0,0));
      add("A_arm_ign",  mk(1,0,0,1, 2,0,1, 0,0,0, 4'h4,4'h0, 0,1,0,0,0));
      add("A_clear",    mk(0,0,1,1, 2,0,1, 0,0,0, 4'h0,4'h0, 0,0,0,0,0));
      add("A_clr_idle", mk(0,0,1,1, 2,0,1, 0,0,0, 4'h4,4'h0, 0,0,0,0,0));
      add("B_arm",      mk(1,0,0,2, 0,0,3, 1,1,2, 4'h0,4'h0, 0,0,1,0,0));
      add("B_p1",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,1));
      add("B_p2",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,2));
      add("B_p3",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h2, 0,0,1,1,0));
      add("B_extra",    mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,1,0));
      add("B_n1",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h0,4'h2, 0,0,1,1,1));
      add("B_n2",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h0,4'h2, 1,1,0,1,0));
      add("B_clear",    mk(0,0,1,2, 0,0,3, 1,1,2, 4'h0,4'h0, 0,0,0,0,0));
      add("C_arm",      mk(1,0,0,0, 3,1,0, 0,0,0, 4'h0,4'h0, 0,0,1,0,0));
      add("C_fire",     mk(0,0,0,0, 3,1,0, 0,0,0, 4'h0,4'h8, 1,1,0,0,0));
      add("C_clear",    mk(0,0,1,0, 3,1,0, 0,0,0, 4'h0,4'h0, 0,0,0,0,0));
      add("D_arm_dis",  mk(1,1,0,1, 1,0,2, 0,0,0, 4'h0,4'h0, 0,0,0,0,0));
      add("D_arm",      mk(1,0,0,1, 1,0,2, 0,0,0, 4'h0,4'h0, 0,0,1,0,0));
      add("D_p1",       mk(0,0,0,1, 1,0,2, 0,0,0, 4'h2,4'h0, 0,0,1,0,1));
      add("D_dis_fin",  mk(0,1,0,1, 1,0,2, 0,0,0, 4'h2,4'h0, 0,0,0,0,0));
      add("D_after",    mk(0,0,0,1, 1,0,2, 0,0,0, 4'h2,4'h0, 0,0,0,0,0));
      add("E_arm",      mk(1,0,0,2, 0,0,3, 1,1,2, 4'h0,4'h0, 0,0,1,0,0));
      add("E_p1",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,1));
      add("E_p2",       mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,2));
      add("E_rearm",    mk(1,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,0));
      add("E_p1b",      mk(0,0,0,2, 0,0,3, 1,1,2, 4'h1,4'h0, 0,0,1,0,1));
      add("E_disarm",   mk(0,1,0,2, 0,0,3, 1,1,2, 4'h0,4'h0, 0,0,0,0,0));
      add("F_arm",      mk(1,0,0,1, 0,0,4, 0,0,0, 4'h0,4'h0, 0,0,1,0,0));
      add("F_p1",       mk(0,0,0,2, 0,0,1, 0,0,0, 4'h1,4'h0, 0,0,1,0,1));
      add("F_p2",       mk(0,0,0,2, 0,0,1, 0,0,0, 4'h1,4'h0, 0,0,1,0,2));
      add("F_p3",       mk(0,0,0,2, 0,0,1, 0,0,0, 4'h1,4'h0, 0,0,1,0,3));
      add("F_p4",       mk(0,0,0,2, 0,0,1, 0,0,0, 4'h1,4'h0, 1,1,0,0,0));
      add("F_clear",    mk(0,0,1,2, 0,0,1, 0,0,0, 4'h0,4'h0, 0,0,0,0,0));
      add("G_arm",      mk(1,0,0,7, 0,0,1, 0,0,1, 4'h0,4'h0, 0,0,1,0,0));
      add("G_1",        mk(0,0,0,7, 0,0,1, 0,0,1, 4'h1,4'h0, 0,0,1,1,0));
      add("G_2",        mk(0,0,0,7, 0,0,1, 0,0,1, 4'h1,4'h0, 0,0,1,2,0));
      add("G_3",        mk(0,0,0,7, 0,0,1, 0,0,1, 4'h1,4'h0, 0,0,1,3,0));
      add("G_4",        mk(0,0,0,7, 0,0,1, 0,0,1, 4'h1,4'h0, 1,1,0,3,0));
      add("G_clear",    mk(0,0,1,7, 0,0,1, 0,0,1, 4'h0,4'h0, 0,0,0,0,0));

      reset_i = 1'b1;
      idle_inputs();
      num_stages_i = '0;
      stage_cfg_i  = '0;
      repeat (2) @(posedge clock_i);
      #1;
      check("reset_state", {trigger_o, triggered_o, busy_o, cur_stage_o, occ_count_o}, 21'h0, 1'b1);
      @(negedge clock_i);
      reset_i = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         run_vec(tbl[i], tags[i]);
      end

      // Synchronous reset while in stage 1 with two occurrences counted.
      run_vec(mk(1,0,0,2, 0,0,3, 1,1,3, 4'h0,4'h0, 0,0,1,0,0), "R_arm");
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h1,4'h0, 0,0,1,0,1), "R_p1");
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h1,4'h0, 0,0,1,0,2), "R_p2");
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h1,4'h0, 0,0,1,1,0), "R_p3");
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h0,4'h2, 0,0,1,1,1), "R_n1");
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h0,4'h2, 0,0,1,1,2), "R_n2");
      @(negedge clock_i);
      reset_i = 1'b1;
      match_neg_i = 4'h2;
      @(posedge clock_i);
      #1;
      check("R_reset", {trigger_o, triggered_o, busy_o, cur_stage_o, occ_count_o}, 21'h0, 1'b1);
      @(negedge clock_i);
      reset_i = 1'b0;
      run_vec(mk(0,0,0,2, 0,0,3, 1,1,3, 4'h1,4'h2, 0,0,0,0,0), "R_after");

      // An unreachable match unit keeps the sequencer waiting indefinitely.
      run_vec(mk(1,0,0,1, 7,0,1, 0,0,0, 4'h0,4'h0, 0,0,1,0,0), "S7_arm");
      for (int c = 0; c < 1000; c++) begin
         @(negedge clock_i);
         match_pos_i = 4'hF;
         match_neg_i = 4'hF;
         arm_i       = 1'b0;
         @(posedge clock_i);
         #1;
         check($sformatf("S7_cycle%0d", c),
               {trigger_o, triggered_o, busy_o, cur_stage_o, occ_count_o},
               {1'b0, 1'b0, 1'b1, 2'd0, 16'd0}, 1'b0);
      end
      $display("ok   S7_hold: 1000 cycles checked");
      run_vec(mk(0,1,0,1, 7,0,1, 0,0,0, 4'hF,4'hF, 0,0,0,0,0), "S7_disarm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
